dcache_wb_line: RTL

Parametrised direct-mapped, write-back, write-allocate data cache with multi-word lines, word-by-word burst refill/writeback and an uncached address window. Sits between the MIPS core's data_sram port and the memory arbiter, replacing the single-word cache. Beyond the previous generation it adds configurable depth and line size, byte enables toward the arbiter, and a one-cycle uncached response slot.

---
 rtl/dcache_wb_line_pkg.sv | 32 +++
 rtl/dcache_wb_line_store.sv | 71 +++++++
 rtl/dcache_wb_line.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_line_pkg.sv
// Shared definitions for the write-back line cache: FSM states,
// uncached window defaults and helpers deriving address-field widths.
package dcache_wb_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_LM    = 3'd2,
        ST_UNC   = 3'd3,
        ST_UDONE = 3'd4
    } state_e;

    localparam int          INDEX_BITS_DEF = 8;
    localparam int          LINE_WORDS_DEF = 4;
    localparam logic [31:0] UNC_BASE_DEF   = 32'h1faf_0000;
    localparam logic [31:0] UNC_MASK_DEF   = 32'hffff_0000;

    // Byte offset width: word select bits plus the two byte bits.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int tag_bits(input int index_bits, input int line_words);
        return 32 - off_bits(line_words) - index_bits;
    endfunction

    // Beat counter / word select width, kept at least one bit wide.
    function automatic int beat_bits(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/dcache_wb_line_store.sv
// Line storage: valid/dirty/tag per line plus the data words.
// Reads are combinational; writes and metadata updates land on posedge.
// Reset clears every valid and dirty bit in a single edge.
module dcache_line_store
    import dcache_wb_line_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int TAG_BITS   = tag_bits(INDEX_BITS_DEF, LINE_WORDS_DEF),
    parameter int BEAT_BITS  = beat_bits(LINE_WORDS_DEF)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic [BEAT_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [BEAT_BITS-1:0]  wr_word,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic                  meta_we,
    input  logic                  meta_valid,
    input  logic                  meta_dirty,
    input  logic [TAG_BITS-1:0]   meta_tag
);

    localparam int NLINES = 1 << INDEX_BITS;

    logic [NLINES-1:0]   valid_q;
    logic [NLINES-1:0]   dirty_q;
    logic [TAG_BITS-1:0] tag_q  [NLINES];
    logic [31:0]         data_q [NLINES][LINE_WORDS];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx][rd_word];

    // Valid/dirty bits: bulk clear on reset, per-line update otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[idx] <= meta_valid;
            dirty_q[idx] <= meta_dirty;
        end
    end

    // Tag array follows metadata writes; no reset needed behind valid.
    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_q[idx] <= meta_tag;
        end
    end

    // Byte-masked word write into the data array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wb_line.sv
// Direct-mapped write-back, write-allocate data cache with multi-word
// lines, burst writeback/refill one word per beat, and an uncached window.
//
// Arbiter handshake: data_cache_req is held high for the whole WB/LM/UNC
// episode; addr/wr/wen/wdata describe the current beat and stay stable
// until a one-cycle data_cache_dok completes it. The following beat is
// presented the cycle after dok. dok in any other state is ignored.
module dcache_wb_line
    import dcache_wb_line_pkg::*;
#(
    parameter int          INDEX_BITS = INDEX_BITS_DEF,
    parameter int          LINE_WORDS = LINE_WORDS_DEF,
    parameter logic [31:0] UNC_BASE   = UNC_BASE_DEF,
    parameter logic [31:0] UNC_MASK   = UNC_MASK_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        d_cache_stall,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_cache_req,
    output logic        data_cache_wr,
    output logic [3:0]  data_cache_wen,
    output logic [31:0] data_cache_addr,
    output logic [31:0] data_cache_wdata,
    input  logic [31:0] data_cache_rdata,
    input  logic        data_cache_dok
);

    localparam int OFF       = off_bits(LINE_WORDS);
    localparam int TAG_BITS  = tag_bits(INDEX_BITS, LINE_WORDS);
    localparam int BEAT_BITS = beat_bits(LINE_WORDS);

    state_e                state_q, state_d;
    logic [BEAT_BITS-1:0]  beat_q;
    logic [31:0]           unc_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [BEAT_BITS-1:0]  req_word;
    logic                  uncached, hit, last_beat;
    logic [31:0]           victim_base, fill_base;

    logic                  rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic [BEAT_BITS-1:0]  rd_word;
    logic                  word_we, meta_we, meta_dirty;
    logic [BEAT_BITS-1:0]  word_sel;
    logic [3:0]            word_be;
    logic [31:0]           word_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^data_sram_addr[1:0];

    assign req_tag   = data_sram_addr[31:OFF+INDEX_BITS];
    assign req_index = data_sram_addr[OFF+INDEX_BITS-1:OFF];

    generate
        if (LINE_WORDS > 1) begin : g_word_sel
            assign req_word = data_sram_addr[OFF-1:2];
        end else begin : g_single_word
            assign req_word = '0;
        end
    endgenerate

    assign uncached    = (data_sram_addr & UNC_MASK) == UNC_BASE;
    assign rd_word     = (state_q == ST_WB) ? beat_q : req_word;
    assign hit         = rd_valid & (rd_tag == req_tag) & ~uncached;
    assign last_beat   = beat_q == BEAT_BITS'(LINE_WORDS - 1);
    assign victim_base = {rd_tag,  req_index, {OFF{1'b0}}};
    assign fill_base   = {req_tag, req_index, {OFF{1'b0}}};

    assign data_sram_rdata = (state_q == ST_UDONE) ? unc_q : rd_data;

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS),
        .BEAT_BITS  (BEAT_BITS)
    ) u_store (
        .clk        (clk),
        .resetn     (resetn),
        .idx        (req_index),
        .rd_word    (rd_word),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (word_we),
        .wr_word    (word_sel),
        .wr_be      (word_be),
        .wr_data    (word_data),
        .meta_we    (meta_we),
        .meta_valid (1'b1),
        .meta_dirty (meta_dirty),
        .meta_tag   (req_tag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Beat counter: held at zero in IDLE, advances on dok, wraps after the last beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_q <= '0;
        end else if (state_q == ST_IDLE) begin
            beat_q <= '0;
        end else if ((state_q == ST_WB || state_q == ST_LM) && data_cache_dok) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Uncached read capture, presented to the core during UDONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            unc_q <= '0;
        end else if (state_q == ST_UNC && data_cache_dok) begin
            unc_q <= data_cache_rdata;
        end
    end

    // Next state, stall, arbiter beat and line-store write controls.
    always_comb begin
        state_d          = state_q;
        d_cache_stall    = 1'b0;
        data_cache_req   = 1'b0;
        data_cache_wr    = 1'b0;
        data_cache_wen   = 4'b0000;
        data_cache_addr  = 32'h0;
        data_cache_wdata = 32'h0;
        word_we          = 1'b0;
        word_sel         = req_word;
        word_be          = 4'b0000;
        word_data        = data_sram_wdata;
        meta_we          = 1'b0;
        meta_dirty       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_sram_en) begin
                    if (uncached) begin
                        d_cache_stall = 1'b1;
                        state_d       = ST_UNC;
                    end else if (hit) begin
                        if (|data_sram_wen) begin
                            word_we    = 1'b1;
                            word_be    = data_sram_wen;
                            meta_we    = 1'b1;
                            meta_dirty = 1'b1;
                        end
                    end else begin
                        d_cache_stall = 1'b1;
                        state_d       = (rd_valid && rd_dirty) ? ST_WB : ST_LM;
                    end
                end
            end
            ST_WB: begin
                d_cache_stall    = 1'b1;
                data_cache_req   = 1'b1;
                data_cache_wr    = 1'b1;
                data_cache_wen   = 4'b1111;
                data_cache_addr  = victim_base | (32'(beat_q) << 2);
                data_cache_wdata = rd_data;
                if (data_cache_dok && last_beat) state_d = ST_LM;
            end
            ST_LM: begin
                d_cache_stall   = 1'b1;
                data_cache_req  = 1'b1;
                data_cache_addr = fill_base | (32'(beat_q) << 2);
                if (data_cache_dok) begin
                    word_we   = 1'b1;
                    word_sel  = beat_q;
                    word_be   = 4'b1111;
                    word_data = data_cache_rdata;
                    if (last_beat) begin
                        meta_we = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNC: begin
                d_cache_stall    = 1'b1;
                data_cache_req   = 1'b1;
                data_cache_wr    = |data_sram_wen;
                data_cache_wen   = data_sram_wen;
                data_cache_addr  = data_sram_addr;
                data_cache_wdata = data_sram_wdata;
                if (data_cache_dok) state_d = ST_UDONE;
            end
            ST_UDONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Reset quiesces the arbiter port and the core stall immediately.
        if (!resetn) begin
            d_cache_stall    = 1'b0;
            data_cache_req   = 1'b0;
            data_cache_wr    = 1'b0;
            data_cache_wen   = 4'b0000;
            data_cache_addr  = 32'h0;
            data_cache_wdata = 32'h0;
            word_we          = 1'b0;
            meta_we          = 1'b0;
        end
    end

endmodule
